// File: rtl/fifo_out_pkg.sv
// fifo_out_pkg: shared types and constants for the FFT output packer.
// Holds the FSM encoding, the bin-header magic, default sizes and the
// widths derived from the default buffer depth.
package fifo_out_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int NFFT_DEF       = 1024;
   localparam int DEPTH_DEF      = 1024;
   localparam int ADDR_W         = $clog2(DEPTH_DEF);
   localparam int CNT_W          = ADDR_W + 1;

   localparam logic [15:0] HDR_MAGIC = 16'hA55A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Upper half of a bin header word: magic, reserved zeros, 0-based bin index.
   function automatic logic [31:0] hdr_tag(input logic [4:0] bin);
      return {HDR_MAGIC, 11'd0, bin};
   endfunction

endpackage

// File: rtl/fifo_out_packer_if.sv
// fifo_out_packer_if: spectrum input stream and packed-word output stream.
// master = source/host side, slave = the packer.
interface fifo_out_packer_if #(
   parameter int DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0]   din;
   logic                    din_valid;
   logic [2*DATA_WIDTH-1:0] dout;
   logic                    dout_valid;
   logic                    dout_ready;

   modport master (
      output din, din_valid, dout_ready,
      input  dout, dout_valid
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output dout, dout_valid
   );

endinterface

// File: rtl/fifo_out_ram.sv
// fifo_out_ram: simple dual-port buffer memory, one write port and one
// registered read port. The read register doubles as the packer's output
// register, so only it carries a reset.
module fifo_out_ram #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port.
   // NOTE: the array has no reset so it maps onto block RAM; a reset here would force flops.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port; old data is returned when reading the slot being written.
   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fifo_out_packer.sv
// fifo_out_packer: keeps the positive-frequency half of each range bin,
// packs point pairs into {odd, even} words, buffers them and drains them to
// the host through a first-word-fall-through valid/ready port.
// Optional feature: define FIFO_OUT_BIN_HEADER_EN to emit one header word
// {16'hA55A, 11'd0, bin_index, 32'd0} at the start of every bin.
module fifo_out_packer
   import fifo_out_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NFFT       = NFFT_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4:0]        nRangeBin,
   fifo_out_packer_if.slave  strm,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              frame_done
);

   localparam int PT_W   = $clog2(NFFT);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;
   localparam int WORD_W = 2 * DATA_WIDTH;

   state_t state_q, state_d;

   logic [PT_W-1:0]       pt_q;
   logic [4:0]            bin_q;
   logic [4:0]            bins_q;
   logic [DATA_WIDTH-1:0] hold_q;

   logic                  stage_vld_q;
   logic [WORD_W-1:0]     stage_word_q;

   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [FILL_W-1:0]     fill_q;
   logic [FILL_W-1:0]     fill_d;
   logic                  dout_valid_q;
   logic [WORD_W-1:0]     rd_data;

   logic                  start_ok;
   logic                  accept;
   logic                  keep_pair;
   logic                  last_point;
   logic                  wr_en;
   logic                  rd_en;
   logic                  drop;

   // A point is consumed only while collecting; the lower half of the bin is
   // kept and every odd index inside it completes a pair.
   assign start_ok   = (state_q == ST_IDLE) && start;
   assign accept     = (state_q == ST_COLLECT) && strm.din_valid;
   assign keep_pair  = accept && !pt_q[PT_W-1] && pt_q[0];
   assign last_point = accept && (pt_q == PT_W'(NFFT - 1)) && (bin_q == bins_q - 5'd1);

   // The output register reloads whenever it is empty or being handed off;
   // a full buffer still accepts a write when a read frees a slot.
   assign rd_en = !empty && (!dout_valid_q || strm.dout_ready);
   assign wr_en = stage_vld_q && (!full || rd_en);
   assign drop  = stage_vld_q && full && !rd_en;

   assign strm.dout       = rd_data;
   assign strm.dout_valid = dout_valid_q;
   assign frame_done      = (state_q == ST_DONE);

   // Frame sequencing: wait for start, collect, drain until nothing is left.
   // NOTE: defaulting every output first keeps this block free of latches.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_COLLECT;
         ST_COLLECT: if (last_point) state_d = ST_DRAIN;
         ST_DRAIN:   if (empty && !dout_valid_q && !stage_vld_q) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Point/bin counters and the even-point holding register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pt_q   <= '0;
         bin_q  <= '0;
         bins_q <= 5'd1;
         hold_q <= '0;
      end else if (start_ok) begin
         pt_q   <= '0;
         bin_q  <= '0;
         bins_q <= (nRangeBin == 5'd0) ? 5'd1 : nRangeBin;
      end else if (accept) begin
         pt_q <= pt_q + PT_W'(1);
         if (pt_q == PT_W'(NFFT - 1)) begin
            bin_q <= bin_q + 5'd1;
         end
         if (!pt_q[0]) begin
            hold_q <= strm.din;
         end
      end
   end

   // Write staging register: one packed word (or bin header) per cycle at most.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_vld_q  <= 1'b0;
         stage_word_q <= '0;
      end else begin
         stage_vld_q <= 1'b0;
         if (keep_pair) begin
            stage_vld_q  <= 1'b1;
            stage_word_q <= {strm.din, hold_q};
         end
`ifdef FIFO_OUT_BIN_HEADER_EN
         else if (accept && (pt_q == '0)) begin
            stage_vld_q  <= 1'b1;
            stage_word_q <= {DATA_WIDTH'(hdr_tag(bin_q)), {DATA_WIDTH{1'b0}}};
         end
`endif
      end
   end

   // Next buffer occupancy; a simultaneous write and read cancel out.
   always_comb begin
      fill_d = fill_q;
      case ({wr_en, rd_en})
         2'b10:   fill_d = fill_q + FILL_W'(1);
         2'b01:   fill_d = fill_q - FILL_W'(1);
         default: fill_d = fill_q;
      endcase
   end

   // Pointers, occupancy flags and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         fill_q <= fill_d;
         full   <= (fill_d == FILL_W'(DEPTH));
         empty  <= (fill_d == '0);
         if (start_ok) begin
            overflow <= 1'b0;
         end else if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Output valid: set on a load, cleared when the host takes the word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_valid_q <= 1'b0;
      end else if (rd_en) begin
         dout_valid_q <= 1'b1;
      end else if (strm.dout_ready) begin
         dout_valid_q <= 1'b0;
      end
   end

   fifo_out_ram #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (stage_word_q),
      .re    (rd_en),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

endmodule
